// File: rtl/audio_pkg.sv
// Shared definitions for the tone/envelope audio path: envelope state encoding
// and the default amplitude and sample-rate constants.
package audio_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  localparam int unsigned PEAK_DEFAULT       = 10000000;
  localparam int unsigned STEP_DEFAULT       = 200000;
  localparam int unsigned SAMPLE_DIV_DEFAULT = 1042;

endpackage

// File: rtl/envelope_fsm.sv
// Attack/sustain/release envelope: advances only on sample ticks, saturating
// the amplitude at PEAK and at zero.
module envelope_fsm
  import audio_pkg::*;
#(
  parameter int unsigned AMP_W = 24,
  parameter int unsigned PEAK  = PEAK_DEFAULT,
  parameter int unsigned STEP  = STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             gate,
  output logic [AMP_W-1:0] amp,
  output env_state_t       state
);

  localparam logic [AMP_W:0] PEAK_X = (AMP_W+1)'(PEAK);
  localparam logic [AMP_W:0] STEP_X = (AMP_W+1)'(STEP);

  env_state_t       state_q, state_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic [AMP_W:0]   up_sum, dn_diff, up_sat, dn_sat;
  logic             go_up, go_dn;

  always_comb begin
    // One guard bit above the amplitude exposes overshoot and borrow.
    up_sum  = {1'b0, amp_q} + STEP_X;
    dn_diff = {1'b0, amp_q} - STEP_X;
    up_sat  = (up_sum >= PEAK_X) ? PEAK_X : up_sum;
    dn_sat  = dn_diff[AMP_W] ? '0 : dn_diff;

    go_up = 1'b0;
    go_dn = 1'b0;
    case (state_q)
      ENV_IDLE:                go_up = gate;
      ENV_ATTACK, ENV_RELEASE: begin
        go_up = gate;
        go_dn = !gate;
      end
      ENV_SUSTAIN:             go_dn = !gate;
      default:                 go_dn = 1'b1;
    endcase

    state_d = state_q;
    amp_d   = amp_q;
    if (tick && go_up) begin
      amp_d   = up_sat[AMP_W-1:0];
      state_d = (up_sat == PEAK_X) ? ENV_SUSTAIN : ENV_ATTACK;
    end else if (tick && go_dn) begin
      amp_d   = dn_sat[AMP_W-1:0];
      state_d = (dn_sat == '0) ? ENV_IDLE : ENV_RELEASE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENV_IDLE;
      amp_q   <= '0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
    end
  end

  assign amp   = amp_q;
  assign state = state_q;

endmodule

// File: rtl/tone_envelope_gen.sv
// Square-wave tone generator with an ADSR-style envelope, feeding an audio
// controller through a pending/allowed write handshake.
module tone_envelope_gen
  import audio_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 19,
  parameter int unsigned SAMPLE_W   = 32,
  parameter int unsigned AMP_W      = 24,
  parameter int unsigned PEAK       = PEAK_DEFAULT,
  parameter int unsigned STEP       = STEP_DEFAULT,
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [PERIOD_W-1:0] period,
  input  logic                enable,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_channel_audio_out,
  output logic [SAMPLE_W-1:0] right_channel_audio_out,
  output logic [1:0]          env_state,
  output logic                overrun
);

  localparam int unsigned         TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] active_q, active_d;
  logic                pol_q, pol_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;

  logic                gate, tick, write;
  logic [AMP_W-1:0]    amp;
  logic [SAMPLE_W-1:0] amp_ext, sample;
  env_state_t          env;

  envelope_fsm #(
    .AMP_W (AMP_W),
    .PEAK  (PEAK),
    .STEP  (STEP)
  ) u_env (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .tick  (tick),
    .gate  (gate),
    .amp   (amp),
    .state (env)
  );

  always_comb begin
    gate       = enable && (period != '0);
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Period changes land only on half-period boundaries; with the gate low the
    // last pitch is kept so the release tail stays audible.
    phase_d  = phase_q;
    pol_d    = pol_q;
    active_d = active_q;
    if (active_q == '0) begin
      phase_d = '0;
      if (gate) active_d = period;
    end else if (phase_q == active_q) begin
      phase_d = '0;
      pol_d   = ~pol_q;
      if (gate) active_d = period;
    end else begin
      phase_d = phase_q + 1'b1;
    end

    amp_ext = SAMPLE_W'(amp);
    sample  = pol_q ? amp_ext : -amp_ext;

    write     = pending_q && audio_out_allowed;
    pending_d = tick || (pending_q && !write);
    overrun_d = overrun_q || (tick && pending_q && !write);
    hold_d    = write ? sample : hold_q;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
      phase_q    <= '0;
      active_q   <= '0;
      pol_q      <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      active_q   <= active_d;
      pol_q      <= pol_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      hold_q     <= hold_d;
    end
  end

  assign write_audio_out         = write;
  assign left_channel_audio_out  = write ? sample : hold_q;
  assign right_channel_audio_out = write ? sample : hold_q;
  assign env_state               = env;
  assign overrun                 = overrun_q;

endmodule

// File: doc/tone_envelope_gen.md
TONE_ENVELOPE_GEN -- requirements
Module: tone_envelope_gen

Interface
REQ-001 SHALL have parameter PERIOD_W, default 19: width of the half-period count in CLOCK_50 cycles.
REQ-002 SHALL have parameter SAMPLE_W, default 32: width of the output sample.
REQ-003 SHALL have parameter AMP_W, default 24: width of the envelope amplitude.
REQ-004 SHALL have parameter PEAK, default 10000000: maximum amplitude.
REQ-005 SHALL have parameter STEP, default 200000: amplitude change per sample tick.
REQ-006 SHALL have parameter SAMPLE_DIV, default 1042: CLOCK_50 cycles per sample tick.
REQ-007 CLOCK_50  in  1  sole clock, rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 period  in  PERIOD_W  requested half-period; 0 means silence.
REQ-010 enable  in  1  note gate; 1 means sound requested.
REQ-011 audio_out_allowed  in  1  audio controller can accept a sample.
REQ-012 write_audio_out  out  1  one-cycle write strobe.
REQ-013 left_channel_audio_out  out  SAMPLE_W  signed sample.
REQ-014 right_channel_audio_out  out  SAMPLE_W  signed sample, always equal to left.
REQ-015 env_state  out  2  envelope state: IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3.
REQ-016 overrun  out  1  sticky flag: a sample tick was lost.

Function
REQ-017 gate SHALL be defined as enable AND (period != 0).
REQ-018 A tick counter SHALL count 0..SAMPLE_DIV-1, wrap to 0, and assert tick for one cycle at the wrap.
REQ-019 A phase counter SHALL count up to active_period; at equality it SHALL clear to 0, toggle polarity, and load active_period from period when gate is high.
REQ-020 When gate is low, active_period SHALL hold its last non-zero value so RELEASE stays audible; a period change while gated SHALL take effect only at the next half-period boundary (glitch-free).
REQ-021 When active_period is 0 (no note since reset), the phase counter SHALL hold at 0, and active_period SHALL load from period on the first cycle gate is high.
REQ-022 Envelope FSM transitions SHALL occur only on tick:
- IDLE to ATTACK when gate is high.
- ATTACK: amp is incremented by STEP, saturating at PEAK; enters SUSTAIN when PEAK is reached.
- SUSTAIN holds amp at PEAK while gate is high.
- gate low in ATTACK or SUSTAIN moves to RELEASE.
- RELEASE: amp is decremented by STEP, saturating at 0; enters IDLE when 0 is reached.
- gate high in RELEASE returns to ATTACK from the current amp (no reset to 0).
REQ-023 Amplitude arithmetic SHALL be AMP_W+1 bits wide to detect saturation; amp SHALL never exceed PEAK or fall below 0.
REQ-024 Sample value SHALL be +amp when polarity is 1 and -amp when polarity is 0, sign-extended to SAMPLE_W; when amp is 0 the sample SHALL be 0.
REQ-025 tick SHALL set pending.
- When pending and audio_out_allowed are both 1, the block SHALL pulse write_audio_out for exactly one cycle.
- In that same cycle it SHALL drive both channel outputs with the current sample and clear pending.
- Outputs SHALL hold their value between writes.
REQ-026 A tick arriving while pending is still 1 SHALL set overrun; pending SHALL stay 1 and only one write SHALL result.
REQ-027 tick and write in the same cycle SHALL leave pending at 1 with no overrun.
REQ-028 Write latency SHALL be 0 cycles from the cycle in which pending and audio_out_allowed are both true.

Reset
REQ-029 Asserting resetn low SHALL immediately force:
- all counters, amp, polarity, active_period, pending and overrun to 0;
- env_state to IDLE;
- write_audio_out to 0;
- both channel outputs to 0.
REQ-030 Reset mid-note SHALL abort without a RELEASE phase; after deassertion the block SHALL resume at tick count 0.

Structure
REQ-031 The envelope state encoding and the default PEAK, STEP and SAMPLE_DIV constants SHALL live in shared package audio_pkg.
REQ-032 The envelope FSM with its amp register SHALL be a single sub-module, envelope_fsm. The phase and handshake logic SHALL remain in the top module.

Verification
REQ-033 Scenario 1: SAMPLE_DIV=4, STEP=2500000, period=191204, enable=1, audio_out_allowed=1 -> env_state reaches SUSTAIN on the 4th tick; amp=10000000; polarity toggles every 191205 cycles.
REQ-034 Scenario 2: enable dropped in SUSTAIN -> 4 ticks of RELEASE giving amp 7500000, 5000000, 2500000, 0, then IDLE; the sample sign keeps alternating at the held period.
REQ-035 Scenario 3: period changed 191204 -> 95510 mid half-period -> the current half-period completes at 191205 cycles, and the next is 95511 cycles.
REQ-036 Scenario 4: audio_out_allowed held low for 2 ticks -> overrun=1 and no write; when raised, exactly one write_audio_out pulse occurs.
REQ-037 Scenario 5: resetn pulsed low during ATTACK -> all outputs read 0 in the same cycle; env_state=IDLE; overrun=0.
REQ-038 Scenario 6: enable re-asserted in RELEASE at amp=5000000 -> the next tick gives ATTACK with amp=7500000.
